// File: rtl/fixed_to_bcd_if.sv
// Request/result bundle between the datapath result register and the BCD converter.
interface fixed_to_bcd_if #(
  parameter int unsigned INT_BITS    = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned INT_DIGITS  = 5,
  parameter int unsigned FRAC_DIGITS = 7
);
  logic                             i_Start;
  logic                             i_Round;
  logic [INT_BITS+FRAC_BITS-1:0]    i_Value;
  logic                             o_Busy;
  logic                             o_Neg;
  logic [INT_DIGITS*4-1:0]          o_Int_BCD;
  logic [FRAC_DIGITS*4-1:0]         o_Frac_BCD;
  logic                             o_Ovf;
  logic                             o_DV;

  modport master (
    output i_Start, i_Round, i_Value,
    input  o_Busy, o_Neg, o_Int_BCD, o_Frac_BCD, o_Ovf, o_DV
  );

  modport slave (
    input  i_Start, i_Round, i_Value,
    output o_Busy, o_Neg, o_Int_BCD, o_Frac_BCD, o_Ovf, o_DV
  );
endinterface

// File: rtl/fixed_to_bcd.sv
// Signed fixed-point to sign + BCD integer/fraction digits, with optional
// round-half-away-from-zero and integer overflow flag. Multi-cycle, one bit/digit per cycle.
module fixed_to_bcd #(
  parameter int unsigned INT_BITS    = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned INT_DIGITS  = 5,
  parameter int unsigned FRAC_DIGITS = 7
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  fixed_to_bcd_if.slave  bus
);

  localparam int unsigned W       = INT_BITS + FRAC_BITS;
  localparam int unsigned ACC_W   = (INT_DIGITS + 1) * 4;
  localparam int unsigned FD_W    = (FRAC_DIGITS + 1) * 4;
  localparam int unsigned ALL_D   = INT_DIGITS + 1 + FRAC_DIGITS;
  localparam int unsigned ALL_W   = ALL_D * 4;
  localparam int unsigned PW      = FRAC_BITS + 4;
  localparam int unsigned CNT_MAX = (INT_BITS > FRAC_DIGITS + 1) ? INT_BITS : FRAC_DIGITS + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  if (FRAC_BITS < 1 || INT_BITS < 2 || INT_DIGITS < 1 || FRAC_DIGITS < 1) begin : g_param_check
    $error("fixed_to_bcd: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INT, S_FRAC, S_ROUND, S_DONE
  } state_t;

  state_t               state;
  logic [W-1:0]         value_q;
  logic                 round_q;
  logic                 sign_q;
  logic [INT_BITS-1:0]  int_sr;
  logic [FRAC_BITS-1:0] frac_q;
  logic [ACC_W-1:0]     acc_q;
  logic [FD_W-1:0]      fd_q;
  logic                 ovf_sticky;
  logic [CNT_W-1:0]     cnt;

  logic [W-1:0]         mag_c;
  logic [ACC_W-1:0]     acc_adj_c;
  logic [PW-1:0]        frac_prod_c;
  logic [ALL_W-1:0]     all_c;
  logic                 rnd_carry_c;
  logic                 digits_nz_c;

  // Unsigned magnitude at full width, so the most negative input is exact.
  assign mag_c       = value_q[W-1] ? (~value_q + W'(1)) : value_q;
  assign frac_prod_c = PW'(frac_q) * PW'(10);

  // Double-dabble add-3 correction ahead of each shift.
  always_comb begin
    acc_adj_c = acc_q;
    for (int i = 0; i < int'(INT_DIGITS + 1); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Decimal increment of {integer digits, fraction digits} driven by the guard digit.
  always_comb begin
    all_c       = {acc_q, fd_q[FD_W-1:4]};
    rnd_carry_c = round_q && (fd_q[3:0] >= 4'd5);
    for (int i = 0; i < int'(ALL_D); i++) begin
      if (rnd_carry_c) begin
        if (all_c[4*i +: 4] == 4'd9) begin
          all_c[4*i +: 4] = 4'd0;
        end else begin
          all_c[4*i +: 4] = all_c[4*i +: 4] + 4'd1;
          rnd_carry_c     = 1'b0;
        end
      end
    end
  end

  assign digits_nz_c = (|all_c[FRAC_DIGITS*4 +: INT_DIGITS*4]) | (|all_c[FRAC_DIGITS*4-1:0]);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= S_IDLE;
      value_q        <= '0;
      round_q        <= 1'b0;
      sign_q         <= 1'b0;
      int_sr         <= '0;
      frac_q         <= '0;
      acc_q          <= '0;
      fd_q           <= '0;
      ovf_sticky     <= 1'b0;
      cnt            <= '0;
      bus.o_Busy     <= 1'b0;
      bus.o_Neg      <= 1'b0;
      bus.o_Int_BCD  <= '0;
      bus.o_Frac_BCD <= '0;
      bus.o_Ovf      <= 1'b0;
      bus.o_DV       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.o_DV <= 1'b0;
          if (bus.i_Start) begin
            value_q    <= bus.i_Value;
            round_q    <= bus.i_Round;
            bus.o_Busy <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          sign_q     <= value_q[W-1];
          int_sr     <= mag_c[W-1:FRAC_BITS];
          frac_q     <= mag_c[FRAC_BITS-1:0];
          acc_q      <= '0;
          fd_q       <= '0;
          ovf_sticky <= 1'b0;
          cnt        <= '0;
          state      <= S_INT;
        end
        S_INT: begin
          // A bit shifted out of the spare top digit means the value exceeds the accumulator.
          acc_q      <= {acc_adj_c[ACC_W-2:0], int_sr[INT_BITS-1]};
          ovf_sticky <= ovf_sticky | acc_adj_c[ACC_W-1];
          int_sr     <= {int_sr[INT_BITS-2:0], 1'b0};
          if (cnt == CNT_W'(INT_BITS - 1)) begin
            cnt   <= '0;
            state <= S_FRAC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FRAC: begin
          fd_q   <= FD_W'({fd_q, frac_prod_c[PW-1 -: 4]});
          frac_q <= frac_prod_c[FRAC_BITS-1:0];
          if (cnt == CNT_W'(FRAC_DIGITS)) begin
            cnt   <= '0;
            state <= S_ROUND;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ROUND: begin
          bus.o_Int_BCD  <= all_c[FRAC_DIGITS*4 +: INT_DIGITS*4];
          bus.o_Frac_BCD <= all_c[FRAC_DIGITS*4-1:0];
          bus.o_Ovf      <= ovf_sticky | rnd_carry_c | (all_c[ALL_W-1 -: 4] != 4'd0);
          bus.o_Neg      <= sign_q & digits_nz_c;
          bus.o_DV       <= 1'b1;
          bus.o_Busy     <= 1'b0;
          state          <= S_DONE;
        end
        S_DONE: begin
          bus.o_DV <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fixed_to_bcd.md
Name: fixed_to_bcd

Overview:
Multi-cycle converter from a signed two's-complement fixed-point value to sign plus BCD integer digits plus BCD fraction digits. Supersedes the fraction-only converter: it adds the integer part, sign handling, a selectable round mode and overflow detection. It sits between the calculator datapath result register and the 7-segment/display formatter.

Parameters:
INT_BITS, 16, integer bits of the input, sign bit included.
FRAC_BITS, 8, fractional bits of the input.
INT_DIGITS, 5, number of BCD integer digits produced.
FRAC_DIGITS, 7, number of BCD fraction digits produced.

Ports:
i_Clock  in  1  system clock, rising edge.
i_Rst_n  in  1  asynchronous, active-low reset.
i_Start  in  1  conversion request; sampled only in IDLE.
i_Round  in  1  round mode, sampled with i_Start: 0 = truncate, 1 = round half away from zero.
i_Value  in  INT_BITS+FRAC_BITS  signed Q(INT_BITS).(FRAC_BITS) input, sampled with i_Start.
o_Busy  out  1  high from the cycle after acceptance until o_DV.
o_Neg  out  1  sign of the displayed result.
o_Int_BCD  out  INT_DIGITS*4  integer digits, most significant digit in the top nibble.
o_Frac_BCD  out  FRAC_DIGITS*4  fraction digits; the top nibble is the 10^-1 digit.
o_Ovf  out  1  integer magnitude does not fit in INT_DIGITS digits.
o_DV  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. All outputs = 0, internal registers = 0.
- FSM: IDLE -> LOAD -> INT -> FRAC -> ROUND -> DONE -> IDLE.
- IDLE: if i_Start=1 at a rising edge, latch i_Value and i_Round, then go to LOAD.
- LOAD (1 cycle):
  - Capture sign = MSB.
  - Magnitude = abs(value), held unsigned at INT_BITS+FRAC_BITS width, so the most negative input is exact.
  - Split the magnitude into integer and fraction fields.
- INT (INT_BITS cycles): double-dabble shift of the integer field into an (INT_DIGITS+1)-digit BCD accumulator. The extra top digit serves overflow detection.
- FRAC (FRAC_DIGITS+1 cycles):
  - Each cycle, frac*10: the top 4 carry bits form the next digit, the low FRAC_BITS bits remain.
  - The first FRAC_DIGITS digits fill o_Frac_BCD order; the last digit is the guard digit.
- ROUND (1 cycle):
  - If i_Round=1 and guard >= 5, add 1 to the least significant fraction digit with decimal carry through the fraction, then into the integer digits.
  - Ovf = (extra top integer digit != 0) after rounding.
- DONE (1 cycle):
  - Register all outputs; o_DV=1 for exactly this cycle; o_Busy=0.
  - o_Neg = sign AND (any output digit != 0), so negative zero displays as +0.
- Latency: i_Start sampled at edge k -> o_DV high after edge k+INT_BITS+FRAC_DIGITS+3 (26 cycles at defaults).
- Outputs other than o_DV and o_Busy hold their last values until the next DONE.
- i_Start while busy: ignored, no queuing.
- i_Start held high continuously: a new conversion is accepted in the IDLE cycle following DONE, with a fresh sample of the inputs.
- On overflow, digits are the low INT_DIGITS of the true value (modulo 10^INT_DIGITS); o_Ovf=1.
- Reset asserted mid-conversion: immediate abort to IDLE; outputs zero; no o_DV.
- Constraints (elaboration check): FRAC_BITS >= 1, INT_BITS >= 2, INT_DIGITS >= 1.

Test Plan:
1. Defaults, i_Value=0x0000A0 (0.625), i_Round=0 -> required: o_Int_BCD=00000, o_Frac_BCD=6250000, o_Neg=0, o_Ovf=0, o_DV exactly 26 cycles after the start edge; a second i_Start pulse while busy has no effect.
2. Defaults, 0xFFFE80 (-1.5), then 0x800000 (-32768.0) -> required: Neg=1/00001/5000000, then Neg=1/32768/0000000, Ovf=0.
3. Defaults, 0x0000FF (0.99609375) -> required: truncate gives 9960937; round gives 9960938.
4. FRAC_DIGITS=2, 0x7FFFFF, i_Round=1 -> required: 32768.00 (carry ripples into the integer digits); with i_Round=0 -> 32767.99.
5. FRAC_DIGITS=2, 0xFFFFFF (-1/256), i_Round=0 -> required: digits all zero, o_Neg=0. INT_DIGITS=4, 0x271000 (10000.0) -> required: o_Ovf=1, o_Int_BCD=0000.
6. Reset pulsed 10 cycles into a conversion -> required: all outputs 0, o_DV never asserts, o_Busy=0; the next i_Start converts correctly.
